// File: rtl/mbus_multi_domain_sleep_ctrl_pkg.sv
// Shared encodings for the multi-domain MBus power-gating sequencer.
package mbus_multi_domain_sleep_ctrl_pkg;

    // Control levels driven onto the power-gating nets
    localparam logic IO_HOLD    = 1'b1;
    localparam logic IO_RELEASE = 1'b0;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_WAKE  = 2'd1,
        SEQ_SLEEP = 2'd2
    } seq_state_e;

    // Action index within a wake or sleep sequence (0..3)
    localparam int unsigned ACT_W = 2;
    typedef logic [ACT_W-1:0] act_idx_t;

    localparam act_idx_t ACT_STEP0 = 2'd0;
    localparam act_idx_t ACT_STEP1 = 2'd1;
    localparam act_idx_t ACT_STEP2 = 2'd2;
    localparam act_idx_t ACT_STEP3 = 2'd3;
    localparam act_idx_t ACT_LAST  = ACT_STEP3;

    // Per-domain control bundle
    typedef struct packed {
        logic isolate;
        logic reset;
        logic clk_en_b;
        logic sleep;
    } dom_ctrl_t;

    localparam dom_ctrl_t DOM_CTRL_HOLD = '{
        isolate:  IO_HOLD,
        reset:    IO_HOLD,
        clk_en_b: IO_HOLD,
        sleep:    IO_HOLD
    };

endpackage

// File: rtl/mbus_sleep_domain_slice.sv
// One power domain: control registers, awake status and auto-wake arming.
module mbus_sleep_domain_slice
    import mbus_multi_domain_sleep_ctrl_pkg::*;
#(
    parameter logic WAKE_ON_RESET = 1'b1
) (
    input  logic      MBUS_CLKIN,
    input  logic      RESETn,
    input  logic      wake_req_i,
    input  logic      sleep_req_i,
    input  logic      apply_i,
    input  logic      wake_dir_i,
    input  act_idx_t  act_i,
    output dom_ctrl_t ctrl_o,
    output logic      awake_o,
    output logic      pend_wake_c_o,
    output logic      pend_sleep_c_o
);

    dom_ctrl_t ctrl_q;
    logic      awake_q;
    logic      auto_q;

    // Wake releases sleep -> clock -> reset -> isolation; sleep holds in reverse
    always_ff @(posedge MBUS_CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            ctrl_q  <= DOM_CTRL_HOLD;
            awake_q <= 1'b0;
            auto_q  <= WAKE_ON_RESET;
        end else if (apply_i) begin
            if (wake_dir_i) begin
                case (act_i)
                    ACT_STEP0: ctrl_q.sleep    <= IO_RELEASE;
                    ACT_STEP1: ctrl_q.clk_en_b <= IO_RELEASE;
                    ACT_STEP2: ctrl_q.reset    <= IO_RELEASE;
                    ACT_STEP3: begin
                        ctrl_q.isolate <= IO_RELEASE;
                        awake_q        <= 1'b1;
                        auto_q         <= 1'b0;
                    end
                endcase
            end else begin
                case (act_i)
                    ACT_STEP0: begin
                        ctrl_q.isolate <= IO_HOLD;
                        awake_q        <= 1'b0;
                    end
                    ACT_STEP1: ctrl_q.reset    <= IO_HOLD;
                    ACT_STEP2: ctrl_q.clk_en_b <= IO_HOLD;
                    ACT_STEP3: ctrl_q.sleep    <= IO_HOLD;
                endcase
            end
        end
    end

    assign ctrl_o  = ctrl_q;
    assign awake_o = awake_q;

    // Conflicting requests cancel each other; the auto-wake bit acts like a held wake request
    assign pend_wake_c_o  = ~awake_q & (wake_req_i | auto_q) & ~sleep_req_i;
    assign pend_sleep_c_o = awake_q & sleep_req_i & ~wake_req_i;

endmodule

// File: rtl/mbus_multi_domain_sleep_ctrl.sv
// Round-robin power-gating sequencer shared across NUM_DOMAINS MBus layer domains.
module mbus_multi_domain_sleep_ctrl
    import mbus_multi_domain_sleep_ctrl_pkg::*;
#(
    parameter int unsigned                NUM_DOMAINS   = 2,
    parameter int unsigned                STEP_CYCLES   = 1,
    parameter logic [NUM_DOMAINS-1:0]     WAKE_ON_RESET = {NUM_DOMAINS{1'b1}}
) (
    input  logic                   MBUS_CLKIN,
    input  logic                   RESETn,
    input  logic [NUM_DOMAINS-1:0] WAKE_REQ,
    input  logic [NUM_DOMAINS-1:0] SLEEP_REQ,
    output logic [NUM_DOMAINS-1:0] MBC_SLEEP,
    output logic [NUM_DOMAINS-1:0] MBC_SLEEP_B,
    output logic [NUM_DOMAINS-1:0] MBC_CLK_EN_B,
    output logic [NUM_DOMAINS-1:0] MBC_CLK_EN,
    output logic [NUM_DOMAINS-1:0] MBC_RESET,
    output logic [NUM_DOMAINS-1:0] MBC_RESET_B,
    output logic [NUM_DOMAINS-1:0] MBC_ISOLATE,
    output logic [NUM_DOMAINS-1:0] MBC_ISOLATE_B,
    output logic [NUM_DOMAINS-1:0] DOMAIN_AWAKE,
    output logic                   BUSY
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);
    localparam int unsigned PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);

    seq_state_e       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_q;
    logic [CNT_W-1:0] cnt_q;
    act_idx_t         act_q;
    logic             busy_q;

    logic [NUM_DOMAINS-1:0] pend_wake_c;
    logic [NUM_DOMAINS-1:0] pend_sleep_c;
    logic [NUM_DOMAINS-1:0] pend_any_c;
    logic [NUM_DOMAINS-1:0] apply_c;
    logic                   found_c;
    logic [PTR_W-1:0]       gnt_idx_c;
    logic [PTR_W-1:0]       ptr_nxt_c;
    logic                   fire_c;
    logic [PTR_W-1:0]       fire_dom_c;
    logic                   fire_wake_c;
    act_idx_t               fire_act_c;

    dom_ctrl_t dom_ctrl [NUM_DOMAINS];

    assign pend_any_c = pend_wake_c | pend_sleep_c;

    // Round-robin search: first pending domain at or after the pointer
    always_comb begin
        found_c   = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned j = 0; j < NUM_DOMAINS; j++) begin
            if (!found_c && pend_any_c[PTR_W'((32'(ptr_q) + j) % NUM_DOMAINS)]) begin
                found_c   = 1'b1;
                gnt_idx_c = PTR_W'((32'(ptr_q) + j) % NUM_DOMAINS);
            end
        end
        ptr_nxt_c = ((32'(gnt_idx_c) + 32'd1) >= NUM_DOMAINS) ? '0
                                                              : PTR_W'(32'(gnt_idx_c) + 32'd1);
    end

    // Which domain takes which action on this edge; action 0 lands on the grant edge itself
    always_comb begin
        fire_c      = 1'b0;
        fire_dom_c  = gnt_q;
        fire_wake_c = (state_q == SEQ_WAKE);
        fire_act_c  = act_q + ACT_W'(1);
        case (state_q)
            SEQ_IDLE: begin
                if (found_c) begin
                    fire_c      = 1'b1;
                    fire_dom_c  = gnt_idx_c;
                    fire_wake_c = pend_wake_c[gnt_idx_c];
                    fire_act_c  = ACT_STEP0;
                end
            end
            SEQ_WAKE, SEQ_SLEEP: fire_c = (cnt_q == '0);
            default: ;
        endcase
        apply_c = '0;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            apply_c[i] = fire_c && (fire_dom_c == PTR_W'(i));
        end
    end

    // Sequencer FSM: arbitrate in IDLE, then pace actions 1..3 with the step counter
    always_ff @(posedge MBUS_CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= SEQ_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            act_q   <= ACT_STEP0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    cnt_q <= '0;
                    if (found_c) begin
                        state_q <= fire_wake_c ? SEQ_WAKE : SEQ_SLEEP;
                        gnt_q   <= gnt_idx_c;
                        ptr_q   <= ptr_nxt_c;
                        act_q   <= ACT_STEP0;
                        cnt_q   <= CNT_RELOAD;
                        busy_q  <= 1'b1;
                    end
                end
                SEQ_WAKE, SEQ_SLEEP: begin
                    if (cnt_q == '0) begin
                        act_q <= fire_act_c;
                        if (fire_act_c == ACT_LAST) begin
                            state_q <= SEQ_IDLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= CNT_RELOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= SEQ_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        mbus_sleep_domain_slice #(
            .WAKE_ON_RESET (WAKE_ON_RESET[g])
        ) u_slice (
            .MBUS_CLKIN     (MBUS_CLKIN),
            .RESETn         (RESETn),
            .wake_req_i     (WAKE_REQ[g]),
            .sleep_req_i    (SLEEP_REQ[g]),
            .apply_i        (apply_c[g]),
            .wake_dir_i     (fire_wake_c),
            .act_i          (fire_act_c),
            .ctrl_o         (dom_ctrl[g]),
            .awake_o        (DOMAIN_AWAKE[g]),
            .pend_wake_c_o  (pend_wake_c[g]),
            .pend_sleep_c_o (pend_sleep_c[g])
        );

        assign MBC_SLEEP[g]    = dom_ctrl[g].sleep;
        assign MBC_CLK_EN_B[g] = dom_ctrl[g].clk_en_b;
        assign MBC_RESET[g]    = dom_ctrl[g].reset;
        assign MBC_ISOLATE[g]  = dom_ctrl[g].isolate;
    end

    assign MBC_SLEEP_B   = ~MBC_SLEEP;
    assign MBC_CLK_EN    = ~MBC_CLK_EN_B;
    assign MBC_RESET_B   = ~MBC_RESET;
    assign MBC_ISOLATE_B = ~MBC_ISOLATE;
    assign BUSY          = busy_q;

endmodule

// File: doc/mbus_multi_domain_sleep_ctrl.md
# mbus_multi_domain_sleep_ctrl

Power-gating sequencer for NUM_DOMAINS independent MBus layer power domains, generalising the single-domain regular sleep controller. It wakes or sleeps domains on level requests and drives per-domain SLEEP/CLK_EN/RESET/ISOLATE controls in a fixed, glitch-free order with a programmable step spacing. It sits beside the MBus bus controller in the always-on domain and is clocked by MBUS_CLKIN.

## Interface
Parameters:
- NUM_DOMAINS, 2: number of controlled domains, 1..8.
- STEP_CYCLES, 1: MBUS_CLKIN cycles between consecutive sequence actions, 1..15.
- WAKE_ON_RESET, {NUM_DOMAINS{1'b1}}: per-domain bit; a set bit creates a wake request after reset release, held until that domain is awake.

Ports (index i = domain; vectors are NUM_DOMAINS wide):
- MBUS_CLKIN  in  1  clock, all state on posedge.
- RESETn  in  1  reset RESETn, asynchronous, active-low; clock MBUS_CLKIN.
- WAKE_REQ  in  N  level wake request per domain.
- SLEEP_REQ  in  N  level sleep request per domain.
- MBC_SLEEP / MBC_SLEEP_B  out  N  power-gate control and complement.
- MBC_CLK_EN_B / MBC_CLK_EN  out  N  clock-gate control (HOLD = clock off) and complement.
- MBC_RESET / MBC_RESET_B  out  N  domain reset and complement.
- MBC_ISOLATE / MBC_ISOLATE_B  out  N  output isolation and complement.
- DOMAIN_AWAKE  out  N  1 = domain fully awake.
- BUSY  out  1  sequencer active.

## Operation
- HOLD = `IO_HOLD, RELEASE = `IO_RELEASE. Every _B output is the exact complement of its partner, combinational.
- Reset (async): all four controls of every domain = HOLD, DOMAIN_AWAKE = 0, BUSY = 0, sequencer IDLE, round-robin pointer = 0, step counter = 0.
- Per-domain status: ASLEEP or AWAKE. Domain i is pending-wake if ASLEEP and (WAKE_REQ[i] or auto-wake bit) and not SLEEP_REQ[i]; pending-sleep if AWAKE and SLEEP_REQ[i] and not WAKE_REQ[i]. Both requests high: no transition.
- One shared sequencer, states IDLE, WAKE, SLEEP. In IDLE, grants the first pending domain at or after the pointer (round-robin); the pointer moves to the granted index + 1, wrapping at NUM_DOMAINS.
- Wake actions, in order: 0 MBC_SLEEP RELEASE; 1 MBC_CLK_EN_B RELEASE; 2 MBC_RESET RELEASE; 3 MBC_ISOLATE RELEASE, DOMAIN_AWAKE = 1, auto-wake bit cleared.
- Sleep actions, in order: 0 MBC_ISOLATE HOLD, DOMAIN_AWAKE = 0; 1 MBC_RESET HOLD; 2 MBC_CLK_EN_B HOLD; 3 MBC_SLEEP HOLD.
- A started sequence always completes. Request changes mid-sequence are ignored until the next IDLE arbitration. Ungranted domains' outputs never change.

## Timing
- Grant at edge k: action n is registered at edge k + n·STEP_CYCLES (n = 0..3). Action 0 is visible after edge k, so grant-to-first-effect latency is 0 cycles beyond the sampling edge.
- After action 3, the FSM enters IDLE. The next grant can occur no earlier than edge k + 3·STEP_CYCLES + 1.
- BUSY is high from edge k to edge k + 3·STEP_CYCLES, and low in the cycle after.
- Step counter width is $clog2(STEP_CYCLES+1). It reloads on each action and saturates at 0 in IDLE.
- Reset asserted mid-sequence: all outputs go to HOLD immediately without waiting for a clock. After release, auto-wake bits are re-armed from WAKE_ON_RESET.
- The first arbitration after reset release happens on the first posedge.

## Structure
- Add state encodings (SEQ_IDLE/SEQ_WAKE/SEQ_SLEEP) and action indices to include/mbus_def.v, next to `IO_HOLD/`IO_RELEASE.
- Sub-module mbus_sleep_domain_slice: one per domain, instantiated via generate. It holds the four control registers, the status bit and the auto-wake bit, and applies the action index when selected. The top level holds the arbiter, pointer, counter and FSM.

## Test plan
- N=2, S=1, WAKE_ON_RESET=2'b11, no requests: release RESETn → domain 0 SLEEP/CLK_EN_B/RESET/ISOLATE release on edges 1,2,3,4; domain 1 on edges 5..8; DOMAIN_AWAKE = 2'b11 after edge 8.
- S=3, domain 0 awake, SLEEP_REQ[0] pulsed high at edge k → ISOLATE HOLD at k, RESET at k+3, CLK_EN_B at k+6, SLEEP at k+9; BUSY low after k+9.
- Both domains awake, SLEEP_REQ = 2'b11 with pointer 1 → domain 1 sequenced first, domain 0 granted at edge k+3S+1.
- WAKE_REQ[0] and SLEEP_REQ[0] both high while ASLEEP → no output change, BUSY stays 0 for 20 cycles.
- RESETn low between wake actions 1 and 2 → all controls HOLD asynchronously, DOMAIN_AWAKE = 0; after release, the auto-wake sequence restarts from action 0.
- Every cycle, assert _B == ~partner, and assert ISOLATE is never RELEASE while RESET or SLEEP is HOLD in the same domain.
